// File: rtl/flag_unit.sv
// flag_unit: condition-flag register {Z,V,N} with update masking by opcode,
// an optional combinational bypass, and a two-state hazard FSM that stalls
// IF/ID for one cycle when a branch in ID needs flags still being produced
// in EX. A saturating counter tracks the number of hazard stall cycles.
module flag_unit #(
  parameter int BYPASS = 0,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [3:0]       ex_opcode,
  input  logic [15:0]      ex_result,
  input  logic             ex_ovfl,
  input  logic             ex_flush,
  input  logic             ex_hold,
  input  logic             id_branch,
  output logic [2:0]       FLAG,
  output logic             flag_stall,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  typedef enum logic {IDLE, WAIT} state_t;

  // Which of {Z,V,N} an opcode is allowed to write.
  function automatic logic [2:0] flag_mask(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB:                 flag_mask = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_mask = 3'b100;
      default:                        flag_mask = 3'b000;
    endcase
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) sat_inc = c;
    else    sat_inc = c + 1'b1;
  endfunction

  logic [2:0]       flag_p1;
  logic [2:0]       mask_p0;
  logic [2:0]       nxt_p0;
  logic [2:0]       merged_p0;
  logic             pend_p0;
  logic             upd_p0;
  logic             hazard;
  state_t           state;
  logic [CNT_W-1:0] cnt_q;

  // EX stage: decode mask, form next flags and merge with the stored flags.
  always_comb begin
    mask_p0   = flag_mask(ex_opcode);
    nxt_p0    = {(ex_result == 16'h0000), ex_ovfl, ex_result[15]};
    merged_p0 = (mask_p0 & nxt_p0) | (~mask_p0 & flag_p1);
    pend_p0   = ex_valid & ~ex_flush & (mask_p0 != 3'b000);
    upd_p0    = pend_p0 & ~ex_hold;
  end

  // Flag register; reset wins over any update, including one left pending.
  always_ff @(posedge clk) begin
    if (rst)         flag_p1 <= 3'b000;
    else if (upd_p0) flag_p1 <= merged_p0;
  end

  // Bypass mode forwards the in-flight flags; registered mode shows storage.
  always_comb begin
    FLAG = flag_p1;
    if ((BYPASS != 0) && pend_p0) FLAG = merged_p0;
  end

  // A branch in ID meeting a flag producer in EX stalls while in IDLE only;
  // WAIT never stalls, so each branch costs at most one stall per producer.
  always_comb begin
    hazard     = (BYPASS == 0) && (state == IDLE) && id_branch && pend_p0;
    flag_stall = hazard && !rst;
  end

  // Hazard FSM: leave IDLE once the producer actually writes (hold dropped).
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (hazard && !ex_hold) state <= WAIT;
        WAIT:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of cycles spent stalling on a flag hazard.
  always_ff @(posedge clk) begin
    if (rst)             cnt_q <= '0;
    else if (flag_stall) cnt_q <= sat_inc(cnt_q);
  end

  assign stall_cnt = cnt_q;

endmodule

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
Parameters:
REQ-001 SHALL have parameter BYPASS, default 0: 1 = FLAG carries next-state flags combinationally, no hazard stall; 0 = registered FLAG plus hazard stall.
REQ-002 SHALL have parameter CNT_W, default 8: width of the stall-event counter.
Ports (name  direction  width  meaning):
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ex_valid  input  1  EX stage holds a real instruction.
REQ-006 SHALL have ex_opcode  input  4  opcode of the EX instruction.
REQ-007 SHALL have ex_result  input  16  ALU result of the EX instruction.
REQ-008 SHALL have ex_ovfl  input  1  signed-overflow indication from the ALU adder.
REQ-009 SHALL have ex_flush  input  1  kill the EX instruction; it SHALL NOT update flags.
REQ-010 SHALL have ex_hold  input  1  pipeline frozen this cycle; no flag update.
REQ-011 SHALL have id_branch  input  1  ID stage holds a B or BR instruction needing FLAG.
REQ-012 SHALL have FLAG  output  3  {Z,V,N}: FLAG[2]=Z, FLAG[1]=V, FLAG[0]=N, matching the branch-condition logic.
REQ-013 SHALL have flag_stall  output  1  stall the IF/ID stages this cycle.
REQ-014 SHALL have stall_cnt  output  CNT_W  saturating count of flag-hazard stall cycles.

Function
REQ-015 Update mask SHALL be: ADD 0000 and SUB 0001 update Z,V,N; XOR 0010, SLL 0100, SRA 0101, ROR 0110 update Z only; all other opcodes update nothing.
REQ-016 Next values: Z = (ex_result == 16'h0000); N = ex_result[15]; V = ex_ovfl. Flags outside the mask SHALL keep their stored value.
REQ-017 Update enable upd = ex_valid & !ex_flush & !ex_hold & (mask != 0); the flag register SHALL load on the rising edge when upd = 1.
REQ-018 A pending-update condition pend = ex_valid & !ex_flush & (mask != 0); ex_hold SHALL NOT clear pend.
REQ-019 BYPASS=0: FLAG SHALL be the stored register value; 1-cycle latency from an EX flag-setting instruction to FLAG.
REQ-020 BYPASS=1: FLAG SHALL equal the masked next-state value when pend = 1, else the stored value; flag_stall SHALL be held at 0.
REQ-021 BYPASS=0 hazard FSM states SHALL be IDLE and WAIT.
REQ-022 IDLE: if id_branch & pend, SHALL assert flag_stall combinationally in the same cycle and go to WAIT when !ex_hold; it SHALL stay in IDLE with flag_stall = 1 while ex_hold = 1.
REQ-023 WAIT: flag_stall SHALL be 0 (the flags are now registered), and the FSM SHALL return to IDLE on the next edge unconditionally.
REQ-024 Back-to-back flag-setting instructions SHALL produce one stall per branch; a branch re-evaluated in WAIT SHALL see the updated FLAG.
REQ-025 A flush arriving with a hazard SHALL suppress the stall, because pend = 0.
REQ-026 stall_cnt SHALL increment by 1 on every cycle with flag_stall = 1 and SHALL saturate at all-ones with no wrap.

Reset
REQ-027 When rst = 1 at an edge: FLAG register = 3'b000, FSM = IDLE, stall_cnt = 0; this SHALL take priority over any update.
REQ-028 flag_stall SHALL be 0 during any cycle in which rst = 1.
REQ-029 Reset asserted mid-WAIT SHALL discard the pending update; no flag write SHALL occur.

Verification
REQ-030 Reset, then SUB with result 0x0000, ovfl=0 -> next cycle FLAG=3'b100, flag_stall stays 0.
REQ-031 Flags = 3'b100, then XOR with result 0x8001 -> FLAG=3'b000 (Z cleared; N, V untouched and remain 0); ADD 0x8000 with ovfl=1 -> FLAG=3'b011.
REQ-032 BYPASS=0: id_branch=1 with ADD in EX -> flag_stall=1 for exactly 1 cycle, FSM IDLE->WAIT->IDLE, stall_cnt +1.
REQ-033 Same hazard with ex_hold=1 for 3 cycles -> flag_stall high for 4 cycles, FLAG unchanged until hold drops, stall_cnt +4.
REQ-034 Hazard with ex_flush=1 -> flag_stall=0 and FLAG unchanged; 300 stall cycles with CNT_W=8 -> stall_cnt=255.
REQ-035 BYPASS=1: SUB result 0x0000 in EX with id_branch=1 -> FLAG[2]=1 in the same cycle and flag_stall=0.
